// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM scan multiplexer: mode encoding and
// the width helper used for the channel select and the dwell counter.
package tdm_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Smallest bit count able to index n items, never below one bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/tdm_scan_ctrl.sv
// Scan sequencer: walks the channel pointer with a programmable dwell
// and flags the final dwell sample of the last channel.
module tdm_scan_ctrl
   import tdm_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int DWELL    = 4,
   parameter int SEL_W    = clog2_min1(CHANNELS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             advance,
   input  logic [SEL_W-1:0] sel,
   output logic [SEL_W-1:0] ptr,
   output logic             last_sample
);

   localparam int CNT_W = clog2_min1(DWELL);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt;
   logic             dwell_done;
   logic             sel_ok;

   assign dwell_done  = (cnt == LAST_CNT);
   assign last_sample = dwell_done && (ptr == LAST_CH);
   assign sel_ok      = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS));

   // Pointer wraps explicitly so non-power-of-two channel counts never
   // reach an unused index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         cnt <= '0;
      end else if (start) begin
         ptr <= sel_ok ? sel : '0;
         cnt <= '0;
      end else if (advance) begin
         if (dwell_done) begin
            cnt <= '0;
            ptr <= (ptr == LAST_CH) ? '0 : ptr + SEL_W'(1);
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/tdm_scan_mux.sv
// Registered N-to-1 channel multiplexer with manual select and an
// automatic time-division scan mode.
module tdm_scan_mux
   import tdm_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   parameter  int DWELL    = 4,
   localparam int SEL_W    = clog2_min1(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] din,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      mode,
   input  logic                      en,
   output logic [WIDTH-1:0]          dout,
   output logic [SEL_W-1:0]          ch_out,
   output logic                      valid,
   output logic                      wrap,
   output logic                      err
);

   logic             mode_q;
   logic             scan_start;
   logic             scan_run;
   logic             sel_ok;
   logic [SEL_W-1:0] start_ch;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] mux_idx;
   logic             last_sample;
   logic [WIDTH-1:0] mux_data;

   assign scan_start = (mode == MODE_SCAN) && (mode_q == MODE_MANUAL);
   assign scan_run   = (mode == MODE_SCAN) && (mode_q == MODE_SCAN);
   assign sel_ok     = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS));
   assign start_ch   = sel_ok ? sel : '0;

   tdm_scan_ctrl #(
      .CHANNELS (CHANNELS),
      .DWELL    (DWELL),
      .SEL_W    (SEL_W)
   ) u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (scan_start),
      .advance     (scan_run && en),
      .sel         (sel),
      .ptr         (ptr),
      .last_sample (last_sample)
   );

   always_comb begin
      mux_idx = sel;
      if (scan_start) begin
         mux_idx = start_ch;
      end else if (scan_run) begin
         mux_idx = ptr;
      end
   end

   // Out-of-range indices select nothing, so the mux yields zero.
   always_comb begin
      mux_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (mux_idx == SEL_W'(k)) mux_data = din[k*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_MANUAL;
      end else begin
         mode_q <= mode;
      end
   end

   // valid is a one-cycle strobe with no backpressure: dout/ch_out/wrap/err
   // describe a new sample exactly when valid=1; dout/ch_out hold otherwise.
   // The scan start edge loads dout but is not a dwell sample, so no strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout   <= '0;
         ch_out <= '0;
         valid  <= 1'b0;
         wrap   <= 1'b0;
         err    <= 1'b0;
      end else begin
         valid <= 1'b0;
         wrap  <= 1'b0;
         err   <= 1'b0;
         if (en) begin
            dout <= mux_data;
            if (scan_start) begin
               ch_out <= start_ch;
            end else if (scan_run) begin
               ch_out <= ptr;
               valid  <= 1'b1;
               wrap   <= last_sample;
            end else begin
               ch_out <= sel;
               valid  <= 1'b1;
               err    <= !sel_ok;
            end
         end
      end
   end

endmodule

// File: doc/tdm_scan_mux.md
# tdm_scan_mux

Parametrised, registered N-to-1 channel multiplexer; the successor to the team's combinational 4-to-1 bit mux. Generalises width and channel count and adds a time-division scan mode that walks the channels automatically with a programmable dwell. It sits between multi-channel sample sources and a single shared downstream consumer, such as a serialiser or a display driver.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- DWELL, 4, enabled cycles spent on each channel in scan mode (≥1)
- SEL_W, derived as clog2(CHANNELS) with a minimum of 1; not user-set

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- din  in  CHANNELS*WIDTH  packed inputs; channel k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  manual channel select; also the scan start channel
- mode  in  1  0 = manual, 1 = scan
- en  in  1  sample enable
- dout  out  WIDTH  registered selected data
- ch_out  out  SEL_W  channel index that dout came from
- valid  out  1  dout updated this cycle
- wrap  out  1  one-cycle pulse on the last dwell sample of channel CHANNELS-1 (scan mode only)
- err  out  1  sel out of range in manual mode

## Operation
- **Reset (async, rst_n=0):** dout=0, ch_out=0, valid=0, wrap=0, err=0. Internal state also clears: ptr=0, cnt=0, mode_q=0.
- **mode_q** samples mode on every edge, regardless of en. A scan start is mode=1 while mode_q=0.
- **en=0:** dout, ch_out and ptr/cnt hold. valid, wrap and err drive 0.
- **Manual mode (mode=0, en=1):**
  - sel < CHANNELS: dout <= din[sel], ch_out <= sel, valid <= 1, err <= 0.
  - sel ≥ CHANNELS: dout <= 0, ch_out <= sel, valid <= 1, err <= 1.
  - ptr/cnt are not touched.
- **Scan start edge:** ptr <= sel, or 0 when sel ≥ CHANNELS. cnt <= 0. The start edge applies whether en is 0 or 1.
  - If en=1 on that edge, dout <= din[sel], with the clamped value used if sel was out of range. The first dwell period begins on the next edge, so the start edge does not count as a dwell sample.
- **Scan mode (mode=1, mode_q=1, en=1):**
  - dout <= din[ptr], ch_out <= ptr, valid <= 1, err <= 0.
  - If cnt == DWELL-1: cnt <= 0, and ptr <= (ptr == CHANNELS-1) ? 0 : ptr+1.
  - Otherwise cnt <= cnt+1.
  - wrap <= (cnt == DWELL-1) && (ptr == CHANNELS-1).
- **Non-power-of-two CHANNELS:** ptr never reaches an invalid index; it wraps explicitly at CHANNELS-1.
- **Leaving scan (mode 1→0):** manual behaviour resumes on that same edge. ptr/cnt freeze and are reloaded at the next scan start.

## Timing
- Latency is 1 cycle from the din/sel sample edge to dout/ch_out/valid.
- There is no combinational path from any input to any output.
- With en held at 1, each channel appears for exactly DWELL consecutive valid cycles. A full scan period is CHANNELS*DWELL cycles.
- With DWELL=1, ptr advances on every enabled edge.
- wrap coincides with the valid cycle whose ch_out = CHANNELS-1 and which is the last dwell sample. wrap is never asserted in manual mode.
- Reset asserted mid-scan: all outputs go to 0 immediately, without waiting for a clock edge. After reset releases with mode=1, the first edge is a scan start, because mode_q=0.
- dwell counter width is clog2(DWELL), with a minimum of 1.

## Structure
- **Shared package `tdm_pkg`:**
  - MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1.
  - clog2-with-minimum-1 function, used for SEL_W and the counter width.
- **Sub-module `tdm_scan_ctrl`:** owns ptr, cnt, the start-load logic and wrap generation. Its outputs are ptr and last_sample.
- **Top level:** holds the mode_q register, the data-select mux and the output registers.

## Test plan
- Reset, then manual mode, WIDTH=8, CHANNELS=4, din = {8'h44, 8'h33, 8'h22, 8'h11}, sel stepped 0..3 with en=1 → dout shows 11, 22, 33, 44 one cycle later, with ch_out matching and valid=1.
- CHANNELS=3, manual sel=3 → dout=0, err=1, valid=1. en=0 on the next cycle → valid=0, err=0, dout holds 0.
- Scan mode, DWELL=2, start with sel=1, en=1 continuously → ch_out sequence after the start cycle is 1,1,2,2,3,3,0,0,1… Each 3,3 pair is followed by the 0,0 pair, and wrap=1 exactly on the second 3.
- Scan with en toggling 1,0,1,0 → ptr/cnt advance only on en=1 cycles. Each channel still gets 2 valid samples, and valid=0 on the en=0 cycles.
- Mid-scan: drop rst_n asynchronously between edges → outputs read 0 before the next edge. Release with mode=1 and sel=2 → scan restarts at channel 2.
- Scan, then mode=0 with sel=0 → manual selection on that same edge. Then mode=1 with sel=3 → scan restarts at channel 3 with cnt=0.
